// File: rtl/cond_pkg.sv
// cond_pkg: shared condition-code and flag definitions for the condition unit.
//   cond_e       4-bit ARM-style condition field encoding (EQ..NV)
//   FLAG_N..V    bit positions of N, Z, C, V inside a {N,Z,C,V} status word
//   uses_flags   1 when a condition depends on the flags (everything but AL/NV)
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int PEND_W = 3;

    // AL and NV share the top three bits 3'b111.
    function automatic logic uses_flags(input logic [3:0] cond);
        return cond[3:1] != 3'b111;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational condition decode.
//   cond  [3:0] in   condition field (cond_e encoding)
//   flags [3:0] in   {N,Z,C,V} flags to evaluate against
//   pass        out  1 when the condition holds on flags
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: status register, flag-writer hazard tracking and condition check
// for the ID stage.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               discard in-flight flag writers, block this cycle's sr load
//   ex_s, status_in     EX-stage flag write and the {N,Z,C,V} value written
//   id_valid, id_cond,  ID-stage instruction, its condition field and whether
//   id_s                it will write flags
//   sr                  registered {N,Z,C,V}
//   cond_pass           ID condition satisfied (0 while stalled/flushed/reset)
//   stall               hold ID this cycle
//   pending             number of issued flag writers not yet at EX
// Optional macro COND_FWD_EN: when the last pending writer is in EX this cycle,
// its status_in is forwarded to the condition check instead of stalling.
module cond_unit
    import cond_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_s,
    input  logic [3:0]        status_in,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    input  logic              id_s,
    output logic [3:0]        sr,
    output logic              cond_pass,
    output logic              stall,
    output logic [PEND_W-1:0] pending
);

    localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_INFLIGHT);

    logic [3:0]        sr_q, sr_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [3:0]        flags;
    logic              fwd, hazard, inc, raw_pass;

`ifdef COND_FWD_EN
    assign fwd = (pending_q == PEND_W'(1)) && ex_s;
`else
    assign fwd = 1'b0;
`endif

    cond_eval u_eval (
        .cond  (id_cond),
        .flags (flags),
        .pass  (raw_pass)
    );

    always_comb begin
        flags  = fwd ? status_in : sr_q;
        hazard = uses_flags(id_cond) && (pending_q != '0) && !fwd;
        // rst_n gating keeps the combinational outputs quiet during reset
        // without waiting for a clock edge.
        stall     = rst_n && !flush && id_valid && (hazard || (id_s && pending_q == MAX_P));
        cond_pass = rst_n && !flush && id_valid && !stall && raw_pass;
        inc       = id_valid && !stall && id_s;
        // A same-cycle issue and retire cancel; a retire with nothing pending
        // saturates at zero.
        pending_d = flush                          ? '0 :
                    (inc && ex_s)                  ? pending_q :
                    inc                            ? pending_q + PEND_W'(1) :
                    (ex_s && pending_q != '0)      ? pending_q - PEND_W'(1) :
                                                     pending_q;
        sr_d      = (ex_s && !flush) ? status_in : sr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            pending_q <= '0;
        end else begin
            sr_q      <= sr_d;
            pending_q <= pending_d;
        end
    end

    assign sr      = sr_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit (MAX_INFLIGHT=3).
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       ex_s = 1'b0;
    logic [3:0] status_in = '0;
    logic       id_valid = 1'b0;
    logic [3:0] id_cond = '0;
    logic       id_s = 1'b0;
    logic [3:0] sr;
    logic       cond_pass;
    logic       stall;
    logic [2:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      nm;
        logic [3:0] sr;
        logic [2:0] pend;
        logic       stall;
        logic       pass;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, MI = 4'h4,
                           GT = 4'hC, AL = 4'hE, NV = 4'hF;

    cond_unit #(.MAX_INFLIGHT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ex_s      (ex_s),
        .status_in (status_in),
        .id_valid  (id_valid),
        .id_cond   (id_cond),
        .id_s      (id_s),
        .sr        (sr),
        .cond_pass (cond_pass),
        .stall     (stall),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference: base test from cond[3:1], odd codes invert; 111x gives AL/NV.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic drive(input logic v, input logic [3:0] c, input logic s,
                         input logic ex, input logic [3:0] st, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v; id_cond = c; id_s = s; ex_s = ex; status_in = st; flush = fl;
    endtask

    task automatic exp_out(input string nm, input logic [3:0] esr, input logic [2:0] ep,
                           input logic est, input logic ecp);
        exp_t e;
        e.nm = nm; e.sr = esr; e.pend = ep; e.stall = est; e.pass = ecp;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %b want %b", nm, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk(mon_e.nm, "sr", sr, mon_e.sr);
            chk(mon_e.nm, "pending", {1'b0, pending}, {1'b0, mon_e.pend});
            chk(mon_e.nm, "stall", {3'b0, stall}, {3'b0, mon_e.stall});
            chk(mon_e.nm, "cond_pass", {3'b0, cond_pass}, {3'b0, mon_e.pass});
        end
    end

    initial begin
        id_valid = 1'b1; id_cond = AL;
        #2 exp_out("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        drive(0, EQ, 0, 1, 4'b0100, 0); exp_out("ex_load", 4'b0000, 3'd0, 0, 0);
        drive(1, EQ, 0, 0, 4'b0000, 0); exp_out("eq_z", 4'b0100, 3'd0, 0, 1);
        drive(1, NE, 0, 0, 4'b0000, 0); exp_out("ne_z", 4'b0100, 3'd0, 0, 0);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("issue_s", 4'b0100, 3'd0, 0, 1);
        drive(1, GT, 0, 0, 4'b0000, 0); exp_out("gt_hazard", 4'b0100, 3'd1, 1, 0);
        drive(1, GT, 0, 1, 4'b0000, 0);
`ifdef COND_FWD_EN
        exp_out("gt_fwd", 4'b0100, 3'd1, 0, 1);
`else
        exp_out("gt_ex_stall", 4'b0100, 3'd1, 1, 0);
`endif
        drive(1, GT, 0, 0, 4'b0000, 0); exp_out("gt_settled", 4'b0000, 3'd0, 0, 1);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("fill0", 4'b0000, 3'd0, 0, 1);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("fill1", 4'b0000, 3'd1, 0, 1);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("fill2", 4'b0000, 3'd2, 0, 1);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("max_stall", 4'b0000, 3'd3, 1, 0);
        drive(1, AL, 1, 1, 4'b0011, 0); exp_out("max_stall_ex", 4'b0000, 3'd3, 1, 0);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("stall_drops", 4'b0011, 3'd2, 0, 1);
        drive(0, EQ, 0, 1, 4'b0101, 0); exp_out("retire", 4'b0011, 3'd3, 0, 0);
        drive(1, EQ, 0, 1, 4'b1111, 1); exp_out("flush_cyc", 4'b0101, 3'd2, 0, 0);
        drive(1, EQ, 0, 0, 4'b0000, 0); exp_out("after_flush", 4'b0101, 3'd0, 0, 1);
        drive(0, EQ, 0, 1, 4'b1000, 0); exp_out("underflow_ex", 4'b0101, 3'd0, 0, 0);
        drive(1, MI, 1, 0, 4'b0000, 0); exp_out("no_underflow", 4'b1000, 3'd0, 0, 1);
        drive(1, AL, 1, 1, 4'b0010, 0); exp_out("inc_dec", 4'b1000, 3'd1, 0, 1);
        drive(1, CS, 0, 0, 4'b0000, 0); exp_out("inc_dec_hold", 4'b0010, 3'd1, 1, 0);
        drive(1, NV, 0, 0, 4'b0000, 0); exp_out("nv_no_stall", 4'b0010, 3'd1, 0, 0);
        drive(1, AL, 1, 0, 4'b0000, 0); exp_out("al_no_stall", 4'b0010, 3'd1, 0, 1);
        drive(1, EQ, 0, 0, 4'b0000, 0); exp_out("stall_p2", 4'b0010, 3'd2, 1, 0);
        drive(1, EQ, 0, 0, 4'b0000, 0);
        #1 rst_n = 1'b0;
        exp_out("async_rst", 4'b0000, 3'd0, 0, 0);
        drive(1, NE, 0, 0, 4'b0000, 0);
        rst_n = 1'b1;
        exp_out("post_rst", 4'b0000, 3'd0, 0, 1);
        for (int f = 0; f < 16; f++) begin
            drive(0, EQ, 0, 1, 4'(f), 0);
            for (int c = 0; c < 16; c++) begin
                drive(1, 4'(c), 0, 0, 4'b0000, 0);
                exp_out($sformatf("sweep_c%0d_f%0d", c, f), 4'(f), 3'd0, 0, ref_pass(4'(c), 4'(f)));
            end
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
